// File: rtl/ccd_pack_pkg.sv
// Shared types and helpers for the CCD pixel packer.
// State encoding, the pixels-per-word helper and the output buffer depth.
package ccd_pack_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  // Depth of the output word buffer in front of the SDRAM write FIFO.
  localparam int OUT_DEPTH = 2;

  // Number of pixel slots in one packed word.
  function automatic int ppw(input int word_w, input int pix_bits);
    return word_w / pix_bits;
  endfunction

endpackage

// File: rtl/ccd_pixel_packer_out_fifo2.sv
// pack_out_fifo2: small output buffer between the packer and the SDRAM port.
// A push into a full buffer is accepted only if a pop frees an entry in the
// same cycle; otherwise the word is discarded and drop_o flags it.
module pack_out_fifo2
  import ccd_pack_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         drop_o
);

  // Pointers wrap naturally because OUT_DEPTH is a power of two.
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic [W-1:0] mem_q [OUT_DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(OUT_DEPTH));
  assign pop     = pop_i & ~empty_o;
  assign push_ok = push_i & (~full | pop);
  assign drop_o  = push_i & ~push_ok;
  // Show zero when nothing is held so stale words never leak onto the bus.
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Storage, pointers and occupancy update on accepted push / pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      if (push_ok && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (pop && !push_ok) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/ccd_pixel_packer.sv
// ccd_pixel_packer: packs thresholded CCD pixels into words for the SDRAM
// write port, entirely on the pixel clock. Optional frame tags (oSOF/oEOF)
// are built when the macro PACKER_FRAME_TAG_EN is defined.
module ccd_pixel_packer
  import ccd_pack_pkg::*;
#(
  parameter int PIX_BITS = 1,
  parameter int WORD_W   = 32,
  parameter int WCNT_W   = 16
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                iEN,
  input  logic [PIX_BITS-1:0] iDATA,
  input  logic                iDVAL,
  input  logic                iFVAL,
  input  logic                iREADY,
  input  logic                iCLR_OVF,
  output logic [WORD_W-1:0]   oDATA,
  output logic                oVALID,
  output logic [WCNT_W-1:0]   oWORD_CNT,
  output logic [15:0]         oFRAME_CNT,
  output logic                oOVF,
  output logic                oBUSY
`ifdef PACKER_FRAME_TAG_EN
  ,
  output logic                oSOF,
  output logic                oEOF
`endif
);

  localparam int PPW   = ppw(WORD_W, PIX_BITS);
  localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;

  if (WORD_W % PIX_BITS != 0) begin : g_bad_width
    $error("ccd_pixel_packer: WORD_W must be a multiple of PIX_BITS");
  end

  state_e            state_q;
  logic              fval_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] acc_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [15:0]       fcnt_q;
  logic              ovf_q;

  logic              fval_rise;
  logic              fval_fall;
  logic              pix_ok;
  logic              word_done;
  logic              frame_start;
  logic              push;
  logic [WORD_W-1:0] acc_wr;
  logic [WORD_W-1:0] push_word;
  logic              empty;
  logic              drop;

  assign fval_rise   = iFVAL & ~fval_q;
  assign fval_fall   = ~iFVAL & fval_q;
  assign pix_ok      = (state_q == ACTIVE) & iDVAL & iFVAL;
  assign word_done   = pix_ok & (idx_q == IDX_W'(PPW - 1));
  // FLUSH behaves like IDLE for a new frame edge, so both may start a frame.
  assign frame_start = fval_rise & iEN & ((state_q == IDLE) | (state_q == FLUSH));
  // Words go straight into the buffer so they are visible one cycle later.
  assign push        = word_done | (state_q == FLUSH);
  assign push_word   = (state_q == FLUSH) ? acc_q : acc_wr;

  // Accumulator with the incoming pixel merged into the current slot.
  for (genvar gi = 0; gi < PPW; gi++) begin : g_slot
    assign acc_wr[gi*PIX_BITS +: PIX_BITS] =
      (idx_q == IDX_W'(gi)) ? iDATA : acc_q[gi*PIX_BITS +: PIX_BITS];
  end

  pack_out_fifo2 #(
    .W(WORD_W)
  ) u_out_fifo (
    .clk_i  (iCLK),
    .rst_ni (iRST_N),
    .push_i (push),
    .data_i (push_word),
    .pop_i  (iREADY),
    .data_o (oDATA),
    .empty_o(empty),
    .drop_o (drop)
  );

  // Frame FSM, slot accumulator, word/frame counters and sticky overflow.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      fval_q  <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      fval_q <= iFVAL;
      // Dropped words still count: the counter reflects what the frame produced.
      if (push && (wcnt_q != '1)) wcnt_q <= wcnt_q + WCNT_W'(1);
      if (drop)          ovf_q <= 1'b1;
      else if (iCLR_OVF) ovf_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q <= ACTIVE;
            idx_q   <= '0;
            acc_q   <= '0;
            wcnt_q  <= '0;
            fcnt_q  <= fcnt_q + 16'd1;
          end
        end
        ACTIVE: begin
          if (pix_ok) begin
            if (word_done) begin
              acc_q <= '0;
              idx_q <= '0;
            end else begin
              acc_q <= acc_wr;
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          if (fval_fall) state_q <= (idx_q != '0) ? FLUSH : IDLE;
        end
        FLUSH: begin
          acc_q <= '0;
          idx_q <= '0;
          if (frame_start) begin
            state_q <= ACTIVE;
            wcnt_q  <= '0;
            fcnt_q  <= fcnt_q + 16'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oVALID     = ~empty;
  assign oWORD_CNT  = wcnt_q;
  assign oFRAME_CNT = fcnt_q;
  assign oOVF       = ovf_q;
  assign oBUSY      = (state_q != IDLE);

`ifdef PACKER_FRAME_TAG_EN
  logic sof_q;
  logic eof_q;

  // One-cycle frame markers: start of capture and after the frame's last push.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sof_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      sof_q <= frame_start;
      eof_q <= (state_q == FLUSH) |
               ((state_q == ACTIVE) & fval_fall & (idx_q == '0));
    end
  end

  assign oSOF = sof_q;
  assign oEOF = eof_q;
`endif

endmodule
